// File: rtl/l2_bank_router.sv
// ============================================================================
//  Module   : l2_bank_router
//  Purpose  : Routes registered CPU requests to one of NUM_BANKS L2 banks by
//             line-address interleaving. It keeps the bank ID of every
//             response-bearing request in an order FIFO, so that read lines
//             return to the CPU strictly in request order.
//  Ports    : clk / rst (async, active-low)
//             cpu_req_*        : CPU request handshake, address, payload
//             bank_req_*       : per-bank request handshake + broadcast data
//             bank_rd_rsp_*    : per-bank read-response handshake + lines
//             rd_rsp_*         : merged in-order response to the CPU
//             outstanding      : order-FIFO occupancy (registered)
//             unexpected_rsp   : sticky flag, bank response with empty FIFO
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_bank_router #(
  parameter int NUM_BANKS       = 2,
  parameter int ADDR_W          = 32,
  parameter int REQ_W           = 72,
  parameter int LINE_W          = 128,
  parameter int BANK_LSB        = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BW = $clog2(NUM_BANKS),
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_req_valid,
  output logic                        cpu_req_ready,
  input  logic [ADDR_W-1:0]           cpu_req_addr,
  input  logic [REQ_W-1:0]            cpu_req_data,
  input  logic                        cpu_req_expects_rsp,
  output logic [NUM_BANKS-1:0]        bank_req_valid,
  input  logic [NUM_BANKS-1:0]        bank_req_ready,
  output logic [NUM_BANKS*REQ_W-1:0]  bank_req_data,
  input  logic [NUM_BANKS-1:0]        bank_rd_rsp_valid,
  output logic [NUM_BANKS-1:0]        bank_rd_rsp_ready,
  input  logic [NUM_BANKS*LINE_W-1:0] bank_rd_rsp_line,
  output logic                        rd_rsp_valid,
  input  logic                        rd_rsp_ready,
  output logic [LINE_W-1:0]           rd_rsp_line,
  output logic [CW-1:0]               outstanding,
  output logic                        unexpected_rsp
);

  localparam int                   PW        = $clog2(MAX_OUTSTANDING);
  localparam logic [CW-1:0]        c_MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [NUM_BANKS-1:0] c_ONE     = NUM_BANKS'(1);

  // Request holding stage
  logic             r_vld;
  logic [BW-1:0]    r_bank;
  logic [REQ_W-1:0] r_data;

  // Order FIFO of bank IDs
  logic [BW-1:0]    r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_err;

  logic [BW-1:0]    w_sel;
  logic [BW-1:0]    w_head;
  logic             w_stage_free;
  logic             w_full;
  logic             w_nonempty;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_unused;

  // Only the bank-select bits matter here; the full address travels in the
  // opaque payload.
  assign w_unused     = ^cpu_req_addr;

  assign w_sel        = cpu_req_addr[BANK_LSB +: BW];
  assign w_head       = r_fifo[r_rd_ptr];
  assign w_stage_free = !r_vld || bank_req_ready[r_bank];
  assign w_full       = (r_count == c_MAX_CNT);
  assign w_nonempty   = (r_count != '0);

  // Gating with rst keeps the CPU stalled for the whole time reset is low.
  // A full FIFO blocks response-bearing requests even if a pop happens in
  // the same cycle: readiness never looks at the pop.
  assign cpu_req_ready = rst && w_stage_free && !(cpu_req_expects_rsp && w_full);
  assign w_accept      = cpu_req_valid && cpu_req_ready;
  assign w_push        = w_accept && cpu_req_expects_rsp;

  assign bank_req_valid = r_vld ? (c_ONE << r_bank) : '0;
  assign bank_req_data  = {NUM_BANKS{r_data}};

  // Response merge is purely combinational. Only the head bank is ever
  // offered ready, so any other bank's response waits at its source.
  assign rd_rsp_valid      = w_nonempty && bank_rd_rsp_valid[w_head];
  assign rd_rsp_line       = bank_rd_rsp_line[int'(w_head)*LINE_W +: LINE_W];
  assign bank_rd_rsp_ready = (rd_rsp_ready && w_nonempty) ? (c_ONE << w_head) : '0;
  assign w_pop             = rd_rsp_valid && rd_rsp_ready;

  assign outstanding    = r_count;
  assign unexpected_rsp = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld  <= 1'b0;
      r_bank <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_vld  <= 1'b1;
      r_bank <= w_sel;
      r_data <= cpu_req_data;
    end else if (w_stage_free) begin
      r_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_fifo[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_sel;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if ((|bank_rd_rsp_valid) && !w_nonempty) begin
      r_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_l2_bank_router.sv
// ============================================================================
//  Module   : tb_l2_bank_router
//  Purpose  : Randomised and directed bench for l2_bank_router. Bank models
//             answer reads with a line derived from the request payload; a
//             monitor compares every handshake against queue-based
//             expectations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_bank_router;

  localparam int NB = 2;
  localparam int AW = 32;
  localparam int RW = 72;
  localparam int LW = 128;
  localparam int BL = 4;
  localparam int MO = 4;
  localparam int CW = $clog2(MO + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cpu_req_valid = 1'b0;
  logic               cpu_req_ready;
  logic [AW-1:0]      cpu_req_addr = '0;
  logic [RW-1:0]      cpu_req_data = '0;
  logic               cpu_req_expects_rsp = 1'b0;
  logic [NB-1:0]      bank_req_valid;
  logic [NB-1:0]      bank_req_ready = '0;
  logic [NB*RW-1:0]   bank_req_data;
  logic [NB-1:0]      bank_rd_rsp_valid = '0;
  logic [NB-1:0]      bank_rd_rsp_ready;
  logic [NB*LW-1:0]   bank_rd_rsp_line = '0;
  logic               rd_rsp_valid;
  logic               rd_rsp_ready = 1'b0;
  logic [LW-1:0]      rd_rsp_line;
  logic [CW-1:0]      outstanding;
  logic               unexpected_rsp;

  l2_bank_router #(
    .NUM_BANKS(NB), .ADDR_W(AW), .REQ_W(RW), .LINE_W(LW),
    .BANK_LSB(BL), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
    .cpu_req_expects_rsp(cpu_req_expects_rsp),
    .bank_req_valid(bank_req_valid), .bank_req_ready(bank_req_ready),
    .bank_req_data(bank_req_data),
    .bank_rd_rsp_valid(bank_rd_rsp_valid), .bank_rd_rsp_ready(bank_rd_rsp_ready),
    .bank_rd_rsp_line(bank_rd_rsp_line),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_line(rd_rsp_line),
    .outstanding(outstanding), .unexpected_rsp(unexpected_rsp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            bank;
    logic [RW-1:0] data;
    logic          rd;
  } stg_t;

  typedef struct {
    int            bank;
    logic [LW-1:0] line;
  } exp_t;

  int            checks = 0;
  int            errors = 0;
  stg_t          stg[$];          // request sitting between CPU and bank
  exp_t          sb[$];           // reads owed to the CPU, in request order
  logic [LW-1:0] bq [NB][$];      // per-bank pending response lines
  logic          err_m   = 1'b0;
  logic          mon_en  = 1'b0;
  logic [LW-1:0] last_line = '0;

  // Environment knobs
  logic [NB-1:0] rdy_mask  = '1;
  logic          rdy_rand  = 1'b0;
  logic [NB-1:0] rsp_en    = '1;
  logic          rsp_rand  = 1'b0;
  logic [NB-1:0] force_rsp = '0;
  logic          rd_rand   = 1'b0;

  function automatic logic [LW-1:0] line_of(input logic [RW-1:0] d);
    return {d[63:0], d[63:0]};
  endfunction

  function automatic logic [NB-1:0] oh(input int b);
    logic [NB-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  task automatic monitor_cycle();
    logic [NB-1:0] exp_rv;
    logic [NB-1:0] exp_rr;
    logic          exp_rdv;
    logic          exp_crdy;
    logic          was_empty;
    exp_t          e;
    stg_t          s;

    chk("outstanding", LW'(outstanding), LW'(sb.size()));
    chk("unexpected_rsp", LW'(unexpected_rsp), LW'(err_m));

    exp_rv = (stg.size() > 0) ? oh(stg[0].bank) : '0;
    chk("bank_req_valid", LW'(bank_req_valid), LW'(exp_rv));
    if (stg.size() > 0)
      chk("bank_req_data", LW'(bank_req_data[stg[0].bank*RW +: RW]), LW'(stg[0].data));

    exp_rdv = (sb.size() > 0) && bank_rd_rsp_valid[sb[0].bank];
    exp_rr  = (rd_rsp_ready && sb.size() > 0) ? oh(sb[0].bank) : '0;
    chk("rd_rsp_valid", LW'(rd_rsp_valid), LW'(exp_rdv));
    chk("bank_rd_rsp_ready", LW'(bank_rd_rsp_ready), LW'(exp_rr));

    exp_crdy = !(cpu_req_expects_rsp && sb.size() == MO) &&
               (stg.size() == 0 || bank_req_ready[stg[0].bank]);
    chk("cpu_req_ready", LW'(cpu_req_ready), LW'(exp_crdy));

    was_empty = (sb.size() == 0);
    if (was_empty && (|bank_rd_rsp_valid)) err_m = 1'b1;

    // merged response to CPU
    if (rd_rsp_valid && rd_rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_with_empty_sb", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rd_rsp_line", rd_rsp_line, e.line);
        last_line = rd_rsp_line;
      end
    end
    // bank side of the response handshake
    for (int b = 0; b < NB; b++) begin
      if (bank_rd_rsp_valid[b] && bank_rd_rsp_ready[b]) begin
        if (bq[b].size() == 0) chk("bank_rsp_pop_empty", 1, 0);
        else void'(bq[b].pop_front());
      end
    end
    // request leaves the holding stage
    for (int b = 0; b < NB; b++) begin
      if (bank_req_valid[b] && bank_req_ready[b]) begin
        if (stg.size() == 0) begin
          chk("bank_req_unexpected", 1, 0);
        end else begin
          s = stg.pop_front();
          chk("bank_req_bank", LW'(b), LW'(s.bank));
          if (s.rd) bq[b].push_back(line_of(s.data));
        end
      end
    end
    // CPU acceptance
    if (cpu_req_valid && cpu_req_ready) begin
      s.bank = int'(cpu_req_addr[BL +: $clog2(NB)]);
      s.data = cpu_req_data;
      s.rd   = cpu_req_expects_rsp;
      stg.push_back(s);
      if (s.rd) begin
        e.bank = s.bank;
        e.line = line_of(s.data);
        sb.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (mon_en) monitor_cycle();
  end

  // ---------------------------------------------------------------- drivers
  task automatic drive_banks();
    for (int b = 0; b < NB; b++) begin
      bank_req_ready[b] = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_mask[b];
      bank_rd_rsp_valid[b] = force_rsp[b] ||
        (rsp_en[b] && bq[b].size() > 0 && (!rsp_rand || $urandom_range(0, 2) != 0));
      bank_rd_rsp_line[b*LW +: LW] = (bq[b].size() > 0) ? bq[b][0] : '0;
    end
    rd_rsp_ready = rd_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    drive_banks();
    cpu_req_valid = 1'b0;
    #2;
  endtask

  // One cycle of a request; returns whether it was accepted.
  task automatic present(input logic [AW-1:0] a, input logic [RW-1:0] d,
                         input logic e, output logic acc);
    @(negedge clk);
    drive_banks();
    cpu_req_valid       = 1'b1;
    cpu_req_addr        = a;
    cpu_req_data        = d;
    cpu_req_expects_rsp = e;
    #2;
    acc = cpu_req_ready;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [RW-1:0] d, input logic e);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) present(a, d, e, acc);
    chk("send_accepted", LW'(acc), 1);
  endtask

  task automatic drain();
    rdy_rand = 1'b0; rdy_mask = '1; rsp_rand = 1'b0; rsp_en = '1; rd_rand = 1'b0;
    for (int i = 0; i < 300 && (sb.size() > 0 || stg.size() > 0); i++) idle();
    chk("drain_done", LW'(sb.size() + stg.size()), 0);
    idle();
  endtask

  // Call at negedge+#2: reset drops between clock edges.
  task automatic async_reset();
    #1;
    mon_en = 1'b0;
    rst = 1'b0;
    cpu_req_valid = 1'b0;
    force_rsp = '0;
    #1;
    chk("rst_cpu_req_ready", LW'(cpu_req_ready), 0);
    chk("rst_outstanding", LW'(outstanding), 0);
    chk("rst_bank_req_valid", LW'(bank_req_valid), 0);
    chk("rst_rd_rsp_valid", LW'(rd_rsp_valid), 0);
    chk("rst_unexpected", LW'(unexpected_rsp), 0);
    sb.delete();
    stg.delete();
    for (int b = 0; b < NB; b++) bq[b].delete();
    err_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    drive_banks();
    #2;
    chk("post_rst_cpu_req_ready", LW'(cpu_req_ready), 1);
  endtask

  // ---------------------------------------------------------------- main
  initial begin : main
    logic          acc;
    logic [RW-1:0] d1;
    logic [RW-1:0] rd;
    logic          re;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_cpu_req_ready", LW'(cpu_req_ready), 0);
    chk("reset_outstanding", LW'(outstanding), 0);
    chk("reset_bank_req_valid", LW'(bank_req_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    drive_banks();
    #2;
    chk("first_cycle_ready", LW'(cpu_req_ready), 1);
    chk("first_cycle_unexpected", LW'(unexpected_rsp), 0);

    // Single read to bank 1
    rsp_en = '0;
    send(32'h10, {RW{1'b1}} & 72'hA5A5A5A5A5A5A5A5A5, 1'b1);
    idle();
    chk("single_bank_req_valid_T1", LW'(bank_req_valid), LW'(2'b10));
    chk("single_outstanding_1", LW'(outstanding), 1);
    rsp_en = '1;
    drain();
    chk("single_rsp_line", last_line, {16{8'hA5}});
    chk("single_outstanding_0", LW'(outstanding), 0);

    // Reorder: bank 1 then bank 0, bank 0 answers first
    rsp_en = 2'b01;
    send(32'h10, 72'h11, 1'b1);
    send(32'h00, 72'h22, 1'b1);
    repeat (6) begin
      idle();
      chk("reorder_rd_rsp_valid_low", LW'(rd_rsp_valid), 0);
      chk("reorder_bank0_ready_low", LW'(bank_rd_rsp_ready[0]), 0);
    end
    chk("reorder_bank0_waiting", LW'(bank_rd_rsp_valid[0]), 1);
    rsp_en = '1;
    drain();
    chk("reorder_last_line_bank0", last_line, line_of(72'h22));

    // Full FIFO
    rsp_en = '0;
    for (int i = 0; i < 4; i++) send(AW'(i * 16), RW'(100 + i), 1'b1);
    idle(); idle();
    chk("full_outstanding_4", LW'(outstanding), 4);
    for (int i = 0; i < 3; i++) begin
      present(32'h50, 72'h555, 1'b1, acc);
      chk("full_read_blocked", LW'(acc), 0);
    end
    present(32'h40, 72'h777, 1'b0, acc);
    chk("full_store_accepted", LW'(acc), 1);
    rsp_en = '1;
    send(32'h50, 72'h555, 1'b1);
    drain();

    // Bank back-pressure and back-to-back throughput
    rdy_mask = 2'b10;
    d1 = 72'hABCDEF0123456789AB;
    send(32'h0, d1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      present(32'h20, 72'h3C3C, 1'b0, acc);
      chk("bp_cpu_ready_low", LW'(acc), 0);
      chk("bp_bank0_valid", LW'(bank_req_valid), LW'(2'b01));
      chk("bp_data_held", LW'(bank_req_data[RW-1:0]), LW'(d1));
    end
    rdy_mask = '1;
    send(32'h20, 72'h3C3C, 1'b0);
    for (int i = 0; i < 8; i++) begin
      present(32'h100 + AW'(i * 32), RW'(i + 7), 1'b0, acc);
      chk("b2b_accept", LW'(acc), 1);
    end
    drain();

    // Unexpected response
    force_rsp = 2'b01;
    idle();
    force_rsp = '0;
    idle();
    chk("unexpected_set", LW'(unexpected_rsp), 1);
    repeat (3) idle();
    chk("unexpected_sticky", LW'(unexpected_rsp), 1);
    async_reset();
    chk("unexpected_cleared", LW'(unexpected_rsp), 0);

    // Randomised traffic
    rdy_rand = 1'b1; rsp_rand = 1'b1; rsp_en = '1; rd_rand = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        rd = {8'($urandom), $urandom, $urandom};
        re = 1'($urandom);
        present($urandom, rd, re, acc);
      end else begin
        idle();
      end
    end
    drain();

    // Async reset with three reads outstanding
    rsp_en = '0;
    send(32'h00, 72'h1, 1'b1);
    send(32'h10, 72'h2, 1'b1);
    send(32'h20, 72'h3, 1'b1);
    idle(); idle();
    chk("midrst_outstanding_3", LW'(outstanding), 3);
    async_reset();
    idle();
    chk("midrst_outstanding_after", LW'(outstanding), 0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
